// File: rtl/hprb_sink_pkg.sv
// Shared sizes and state encoding for the probe sink.
package hprb_sink_pkg;

   localparam int unsigned NS_ADDRESS_SIZE = 8;
   localparam int unsigned NS_DATA_SIZE    = 16;
   localparam int unsigned NS_REDUN_SIZE   = 4;
   localparam int unsigned NS_REQ_CKS      = 3;
   localparam int unsigned SEQ_W           = 4;

   typedef enum logic [1:0] {
      StInit  = 2'd0,
      StIdle  = 2'd1,
      StCheck = 2'd2,
      StAck   = 2'd3
   } sink_state_e;

endpackage

// File: rtl/calc_redun.sv
// Redundancy code of a message: XOR fold of {src, dst, dat} into RSZ-bit chunks.
module calc_redun #(
   parameter int unsigned ASZ = 8,
   parameter int unsigned DSZ = 16,
   parameter int unsigned RSZ = 4
) (
   input  logic [ASZ-1:0] src,
   input  logic [ASZ-1:0] dst,
   input  logic [DSZ-1:0] dat,
   output logic [RSZ-1:0] red
);

   localparam int unsigned TOT = 2 * ASZ + DSZ;
   localparam int unsigned NCH = (TOT + RSZ - 1) / RSZ;
   localparam int unsigned PW  = NCH * RSZ;

   logic [PW-1:0] flat;

   // Zero-pad to a whole number of chunks so the fold needs no edge case.
   assign flat = PW'({src, dst, dat});

   always_comb begin
      red = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         red = red ^ flat[i*RSZ +: RSZ];
      end
   end

endmodule

// File: rtl/ns_debouncer_req.sv
// Request level filter: the output follows req_in only after CKS stable cycles.
module ns_debouncer_req #(
   parameter int unsigned CKS = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic req_in,
   output logic req_ckd
);

   localparam int unsigned CW = (CKS > 1) ? $clog2(CKS) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          ckd_q, ckd_d;

   // Count resets whenever the input agrees with the filtered level, so any glitch restarts it.
   always_comb begin
      cnt_d = '0;
      ckd_d = ckd_q;
      if (clr) begin
         ckd_d = 1'b0;
      end else if (req_in != ckd_q) begin
         if (cnt_q == CW'(CKS - 1)) begin
            ckd_d = req_in;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         ckd_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ckd_q <= ckd_d;
      end
   end

   assign req_ckd = ckd_q;

endmodule

// File: rtl/hprb_sink.sv
// Probe sink: accepts messages over a 4-phase req/ack handshake and tallies link errors.
module hprb_sink
   import hprb_sink_pkg::*;
#(
   parameter int unsigned MY_LOCAL_ADDR = 0,
   parameter int unsigned PRB_SRC_ADDR  = 0,
   parameter int unsigned ASZ           = NS_ADDRESS_SIZE,
   parameter int unsigned DSZ           = NS_DATA_SIZE,
   parameter int unsigned RSZ           = NS_REDUN_SIZE,
   parameter int unsigned RCV_REQ_CKS   = NS_REQ_CKS,
   parameter int unsigned CNT_SZ        = 16
) (
   input  logic              gch_clk,
   input  logic              gch_reset,
   output logic              gch_ready,
   input  logic [ASZ-1:0]    rcv0_src,
   input  logic [ASZ-1:0]    rcv0_dst,
   input  logic [DSZ-1:0]    rcv0_dat,
   input  logic [RSZ-1:0]    rcv0_red,
   input  logic              rcv0_req_in,
   output logic              rcv0_ack_out,
   output logic [CNT_SZ-1:0] o_rx_cnt,
   output logic [CNT_SZ-1:0] o_err_cnt,
   output logic              o_err_dst,
   output logic              o_err_red,
   output logic              o_err_seq,
   output logic [DSZ-1:0]    o_last_dat
);

   sink_state_e       state_q, state_d;
   logic              ready_q, ready_d, ack_q, ack_d;
   logic              req_ckd, filter_clr;
   logic [ASZ-1:0]    src_q, src_d, dst_q, dst_d;
   logic [DSZ-1:0]    dat_q, dat_d, last_q, last_d;
   logic [RSZ-1:0]    red_q, red_d, red_calc;
   logic [CNT_SZ-1:0] rx_q, rx_d, err_q, err_d;
   logic              err_dst_q, err_dst_d, err_red_q, err_red_d, err_seq_q, err_seq_d;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic              bad_dst, bad_red, bad_seq;

   assign filter_clr = (state_q == StInit);

   ns_debouncer_req #(
      .CKS(RCV_REQ_CKS)
   ) u_req_filter (
      .clk    (gch_clk),
      .rst_n  (gch_reset),
      .clr    (filter_clr),
      .req_in (rcv0_req_in),
      .req_ckd(req_ckd)
   );

   calc_redun #(
      .ASZ(ASZ),
      .DSZ(DSZ),
      .RSZ(RSZ)
   ) u_redun (
      .src(src_q),
      .dst(dst_q),
      .dat(dat_q),
      .red(red_calc)
   );

   assign bad_dst = (dst_q != ASZ'(MY_LOCAL_ADDR)) || (src_q != ASZ'(PRB_SRC_ADDR));
   assign bad_red = (red_q != red_calc);
   assign bad_seq = (dat_q[SEQ_W-1:0] != seq_q);

   always_comb begin
      state_d   = state_q;
      ready_d   = ready_q;
      ack_d     = ack_q;
      src_d     = src_q;
      dst_d     = dst_q;
      dat_d     = dat_q;
      red_d     = red_q;
      rx_d      = rx_q;
      err_d     = err_q;
      last_d    = last_q;
      err_dst_d = err_dst_q;
      err_red_d = err_red_q;
      err_seq_d = err_seq_q;
      seq_d     = seq_q;
      unique case (state_q)
         StInit: begin
            src_d     = '0;
            dst_d     = '0;
            dat_d     = '0;
            red_d     = '0;
            rx_d      = '0;
            err_d     = '0;
            last_d    = '0;
            err_dst_d = 1'b0;
            err_red_d = 1'b0;
            err_seq_d = 1'b0;
            seq_d     = '0;
            ack_d     = 1'b0;
            ready_d   = 1'b1;
            state_d   = StIdle;
         end
         StIdle: begin
            if (req_ckd) begin
               src_d   = rcv0_src;
               dst_d   = rcv0_dst;
               dat_d   = rcv0_dat;
               red_d   = rcv0_red;
               state_d = StCheck;
            end
         end
         StCheck: begin
            rx_d      = (rx_q == '1) ? rx_q : rx_q + 1'b1;
            last_d    = dat_q;
            err_dst_d = err_dst_q | bad_dst;
            err_red_d = err_red_q | bad_red;
            err_seq_d = err_seq_q | bad_seq;
            if (bad_dst || bad_red || bad_seq) begin
               err_d = (err_q == '1) ? err_q : err_q + 1'b1;
            end
            // Resync to the received number so a gap counts as one error.
            seq_d   = dat_q[SEQ_W-1:0] + 1'b1;
            ack_d   = 1'b1;
            state_d = StAck;
         end
         StAck: begin
            if (!req_ckd) begin
               ack_d   = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge gch_clk or negedge gch_reset) begin
      if (!gch_reset) begin
         state_q   <= StInit;
         ready_q   <= 1'b0;
         ack_q     <= 1'b0;
         src_q     <= '0;
         dst_q     <= '0;
         dat_q     <= '0;
         red_q     <= '0;
         rx_q      <= '0;
         err_q     <= '0;
         last_q    <= '0;
         err_dst_q <= 1'b0;
         err_red_q <= 1'b0;
         err_seq_q <= 1'b0;
         seq_q     <= '0;
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         ack_q     <= ack_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         dat_q     <= dat_d;
         red_q     <= red_d;
         rx_q      <= rx_d;
         err_q     <= err_d;
         last_q    <= last_d;
         err_dst_q <= err_dst_d;
         err_red_q <= err_red_d;
         err_seq_q <= err_seq_d;
         seq_q     <= seq_d;
      end
   end

   assign gch_ready    = ready_q;
   assign rcv0_ack_out = ack_q;
   assign o_rx_cnt     = rx_q;
   assign o_err_cnt    = err_q;
   assign o_err_dst    = err_dst_q;
   assign o_err_red    = err_red_q;
   assign o_err_seq    = err_seq_q;
   assign o_last_dat   = last_q;

endmodule

// File: tb/tb_hprb_sink.sv
// Bench for hprb_sink: directed scenarios plus random traffic against a message-level model.
module tb_hprb_sink;

   localparam int unsigned ASZ = 8;
   localparam int unsigned DSZ = 16;
   localparam int unsigned RSZ = 4;
   localparam int unsigned CKS = 3;
   localparam logic [7:0]  MY_A  = 8'h05;
   localparam logic [7:0]  PRB_A = 8'h09;

   logic           clk   = 1'b0;
   logic           rst_n = 1'b1;
   logic           req   = 1'b0;
   logic [ASZ-1:0] src = '0, dst = '0;
   logic [DSZ-1:0] dat = '0;
   logic [RSZ-1:0] red = '0;

   logic           ready_a, ack_a, ed_a, er_a, es_a;
   logic [15:0]    rx_a, ec_a;
   logic [DSZ-1:0] last_a;
   logic           ready_b, ack_b, ed_b, er_b, es_b;
   logic [3:0]     rx_b, ec_b;
   logic [DSZ-1:0] last_b;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Message currently offered by the driver (pins may be scrambled while ack is high).
   logic [ASZ-1:0] cur_src = '0, cur_dst = '0;
   logic [DSZ-1:0] cur_dat = '0;
   logic [RSZ-1:0] cur_red = '0;

   int unsigned    mdl_rx, mdl_err;
   bit             mdl_ed, mdl_er, mdl_es;
   logic [DSZ-1:0] mdl_last;
   logic [3:0]     mdl_seq;
   int unsigned    edges_up = 0;
   logic [3:0]     seq_next = 4'd0;

   always #5 clk = ~clk;

   hprb_sink #(
      .MY_LOCAL_ADDR(MY_A), .PRB_SRC_ADDR(PRB_A), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ),
      .RCV_REQ_CKS(CKS), .CNT_SZ(16)
   ) u_dut (
      .gch_clk(clk), .gch_reset(rst_n), .gch_ready(ready_a),
      .rcv0_src(src), .rcv0_dst(dst), .rcv0_dat(dat), .rcv0_red(red),
      .rcv0_req_in(req), .rcv0_ack_out(ack_a),
      .o_rx_cnt(rx_a), .o_err_cnt(ec_a), .o_err_dst(ed_a), .o_err_red(er_a),
      .o_err_seq(es_a), .o_last_dat(last_a)
   );

   hprb_sink #(
      .MY_LOCAL_ADDR(MY_A), .PRB_SRC_ADDR(PRB_A), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ),
      .RCV_REQ_CKS(CKS), .CNT_SZ(4)
   ) u_sat (
      .gch_clk(clk), .gch_reset(rst_n), .gch_ready(ready_b),
      .rcv0_src(src), .rcv0_dst(dst), .rcv0_dat(dat), .rcv0_red(red),
      .rcv0_req_in(req), .rcv0_ack_out(ack_b),
      .o_rx_cnt(rx_b), .o_err_cnt(ec_b), .o_err_dst(ed_b), .o_err_red(er_b),
      .o_err_seq(es_b), .o_last_dat(last_b)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h, t=%0t", name, got, exp, $time);
   endtask

   function automatic logic [RSZ-1:0] redun(input logic [ASZ-1:0] s, input logic [ASZ-1:0] d,
                                            input logic [DSZ-1:0] x);
      logic [2*ASZ+DSZ-1:0] v;
      logic [RSZ-1:0]       r;
      v = {s, d, x};
      r = '0;
      for (int i = 0; i < 2 * ASZ + DSZ; i++) r[i % RSZ] = r[i % RSZ] ^ v[i];
      return r;
   endfunction

   function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_clear();
      mdl_rx = 0; mdl_err = 0; mdl_ed = 0; mdl_er = 0; mdl_es = 0;
      mdl_last = '0; mdl_seq = 4'd0;
   endtask

   task automatic model_accept();
      bit e_d, e_r, e_s;
      e_d = (cur_dst != MY_A) || (cur_src != PRB_A);
      e_r = (cur_red != redun(cur_src, cur_dst, cur_dat));
      e_s = (cur_dat[3:0] != mdl_seq);
      mdl_rx++;
      if (e_d || e_r || e_s) mdl_err++;
      mdl_ed |= e_d; mdl_er |= e_r; mdl_es |= e_s;
      mdl_last = cur_dat;
      mdl_seq  = cur_dat[3:0] + 4'd1;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edges_up <= 0;
      else if (edges_up == 0) edges_up <= 1;
   end

   initial begin : compare
      logic prev_ack;
      bit   exp_ready;
      prev_ack = 1'b0;
      model_clear();
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            model_clear();
            prev_ack = 1'b0;
         end else if (ack_a && !prev_ack) begin
            model_accept();
         end
         prev_ack  = ack_a;
         exp_ready = rst_n && (edges_up != 0);
         check("ready_a", ready_a, exp_ready);
         check("ready_b", ready_b, exp_ready);
         check("rx_a", rx_a, sat(mdl_rx, 16'hFFFF));
         check("rx_b", rx_b, sat(mdl_rx, 15));
         check("errcnt_a", ec_a, sat(mdl_err, 16'hFFFF));
         check("errcnt_b", ec_b, sat(mdl_err, 15));
         check("err_dst", {ed_b, ed_a}, {mdl_ed, mdl_ed});
         check("err_red", {er_b, er_a}, {mdl_er, mdl_er});
         check("err_seq", {es_b, es_a}, {mdl_es, mdl_es});
         check("last_a", last_a, mdl_last);
         check("last_b", last_b, mdl_last);
      end
   end

   task automatic load(input logic [3:0] sq, input bit bad_red, input bit bad_dst,
                       input bit bad_src);
      logic [11:0] hi;
      hi      = 12'($urandom);
      cur_src = bad_src ? (PRB_A ^ 8'h10) : PRB_A;
      cur_dst = bad_dst ? (MY_A + 8'd1) : MY_A;
      cur_dat = {hi, sq};
      cur_red = redun(cur_src, cur_dst, cur_dat);
      if (bad_red) cur_red[0] = ~cur_red[0];
      src = cur_src; dst = cur_dst; dat = cur_dat; red = cur_red;
   endtask

   task automatic send();
      int n;
      @(posedge clk); #1;
      req = 1'b1;
      n   = 0;
      while (ack_a !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
      check("ack_rise_latency", n, CKS + 2);
      check("ack_rise_b", ack_b, 1'b1);
      src = 8'($urandom); dst = 8'($urandom); dat = 16'($urandom); red = 4'($urandom);
      req = 1'b0;
      n   = 0;
      while (ack_a !== 1'b0 && n < 40) begin @(posedge clk); #1; n++; end
      check("ack_fall_latency", n, CKS + 1);
   endtask

   task automatic glitch();
      bit seen;
      seen = 1'b0;
      @(posedge clk); #1;
      req = 1'b1;
      repeat (CKS - 1) begin @(posedge clk); #1; if (ack_a || ack_b) seen = 1'b1; end
      req = 1'b0;
      repeat (2 * CKS + 4) begin @(posedge clk); #1; if (ack_a || ack_b) seen = 1'b1; end
      check("glitch_no_ack", seen, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("reset_ack", ack_a, 1'b0);
      check("reset_rx", rx_a, 16'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("ready_after_release", ready_a, 1'b1);
      seq_next = 4'd0;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

   initial begin : driver
      int unsigned r;
      int          n;
      logic [3:0]  sq;
      #1 rst_n = 1'b0;
      #2;
      check("por_ready", ready_a, 1'b0);
      check("por_rx", rx_a, 16'd0);
      check("model_redun_pin", redun(PRB_A, MY_A, 16'h0000), 4'hC);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("por_ready_release", ready_a, 1'b1);

      // T1 + T6: twenty in-order messages, seq wraps; the 4-bit build saturates
      for (int i = 0; i < 20; i++) begin load(4'(i), 0, 0, 0); send(); end
      check("t1_rx", rx_a, 16'd20);
      check("t1_errcnt", ec_a, 16'd0);
      check("t1_flags", {ed_a, er_a, es_a}, 3'b000);
      check("t1_last_seq", last_a[3:0], 4'd3);
      check("t6_rx_sat", rx_b, 4'd15);

      // T2: seq gap gives one error
      do_reset();
      load(4'd0, 0, 0, 0); send();
      load(4'd1, 0, 0, 0); send();
      load(4'd3, 0, 0, 0); send();
      load(4'd4, 0, 0, 0); send();
      check("t2_err_seq", es_a, 1'b1);
      check("t2_errcnt", ec_a, 16'd1);
      check("t2_rx", rx_a, 16'd4);

      // T3: redundancy then destination error
      do_reset();
      load(4'd0, 1, 0, 0); send();
      check("t3_err_red", er_a, 1'b1);
      check("t3_errcnt1", ec_a, 16'd1);
      load(4'd1, 0, 1, 0); send();
      check("t3_err_dst", ed_a, 1'b1);
      check("t3_errcnt2", ec_a, 16'd2);

      // T4: short req pulse is filtered out
      do_reset();
      load(4'd0, 0, 0, 0);
      glitch();
      check("t4_rx_unchanged", rx_a, 16'd0);
      send();
      check("t4_rx_after", rx_a, 16'd1);
      check("t4_errcnt", ec_a, 16'd0);

      // T5: reset while ack is high, upstream drops req and re-handshakes
      load(4'd1, 0, 0, 0);
      @(posedge clk); #1 req = 1'b1;
      n = 0;
      while (ack_a !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
      check("t5_ack_high", ack_a, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_ack_async_drop", ack_a, 1'b0);
      check("t5_rx_cleared", rx_a, 16'd0);
      check("t5_errcnt_cleared", ec_a, 16'd0);
      req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("t5_ready_1cyc", ready_a, 1'b1);
      load(4'd0, 0, 0, 0); send();
      check("t5_seq0_ok", es_a, 1'b0);
      check("t5_rx", rx_a, 16'd1);

      // Req already high across reset release is accepted after init
      load(4'd0, 0, 0, 0);
      @(posedge clk); #1 rst_n = 1'b0; req = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      n = 0;
      while (ack_a !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
      check("rel_req_high_ack", ack_a, 1'b1);
      req = 1'b0;
      n = 0;
      while (ack_a !== 1'b0 && n < 40) begin @(posedge clk); #1; n++; end
      check("rel_req_high_fall", ack_a, 1'b0);
      check("rel_req_high_rx", rx_a, 16'd1);
      check("rel_req_high_seq", es_a, 1'b0);
      seq_next = 4'd1;

      // Random traffic
      repeat (70) begin
         r = $urandom_range(0, 11);
         if (r == 0) begin
            glitch();
         end else if (r == 1) begin
            do_reset();
         end else begin
            sq = (r == 2) ? 4'($urandom) : seq_next;
            load(sq, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0);
            send();
            seq_next = sq + 4'd1;
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      @(negedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
